// File: rtl/adder_share_arbiter.sv
// Round-robin sequencer sharing one self-timed 4-phase bundled-data adder among NUM_REQ clocked requesters.
// Adder-side handshakes are synchronized into clk before the FSM looks at them.
module adder_share_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 13,
  parameter int unsigned SYNC    = 2,
  localparam int unsigned GW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       reqIn,
  input  logic [NUM_REQ*WIDTH-1:0] opA,
  input  logic [NUM_REQ*WIDTH-1:0] opB,
  output logic [NUM_REQ-1:0]       ackOut,
  output logic [WIDTH-1:0]         sumOut,
  output logic [GW-1:0]            grantId,
  output logic                     busy,
  output logic                     accumReq,
  output logic [WIDTH-1:0]         accumData,
  input  logic                     accumAck,
  output logic                     multReq,
  output logic [WIDTH-1:0]         multData,
  input  logic                     multAck,
  input  logic                     adderReq,
  input  logic [WIDTH-1:0]         adderData,
  output logic                     adderAck
);

  typedef enum logic [2:0] {IDLE, SETUP, ISSUE, COLLECT, CLOSE, RESPOND} state_t;

  state_t            state;
  logic [GW-1:0]     ptr;
  logic [GW-1:0]     nxt_ptr;
  logic [GW-1:0]     pick;
  logic              pick_valid;
  logic [SYNC-1:0]   sync_a;
  logic [SYNC-1:0]   sync_m;
  logic [SYNC-1:0]   sync_r;
  logic              s_a;
  logic              s_m;
  logic              s_r;
  logic [WIDTH-1:0]  opa_arr [NUM_REQ];
  logic [WIDTH-1:0]  opb_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign opa_arr[i] = opA[i*WIDTH +: WIDTH];
    assign opb_arr[i] = opB[i*WIDTH +: WIDTH];
  end

  // Multi-flop synchronizers on the three asynchronous adder handshakes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_a <= '0;
      sync_m <= '0;
      sync_r <= '0;
    end else begin
      sync_a <= {sync_a[SYNC-2:0], accumAck};
      sync_m <= {sync_m[SYNC-2:0], multAck};
      sync_r <= {sync_r[SYNC-2:0], adderReq};
    end
  end

  assign s_a = sync_a[SYNC-1];
  assign s_m = sync_m[SYNC-1];
  assign s_r = sync_r[SYNC-1];

  // First pending requester at or after the round-robin pointer, wrapping
  always_comb begin
    logic [GW-1:0] cand;
    pick       = '0;
    pick_valid = 1'b0;
    cand       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = GW'((32'(ptr) + k) % NUM_REQ);
      if (!pick_valid && reqIn[cand]) begin
        pick_valid = 1'b1;
        pick       = cand;
      end
    end
  end

  assign nxt_ptr = (grantId == GW'(NUM_REQ - 1)) ? '0 : grantId + GW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= '0;
      grantId   <= '0;
      busy      <= 1'b0;
      accumReq  <= 1'b0;
      multReq   <= 1'b0;
      accumData <= '0;
      multData  <= '0;
      sumOut    <= '0;
      adderAck  <= 1'b0;
      ackOut    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grantId   <= pick;
            accumData <= opa_arr[pick];
            multData  <= opb_arr[pick];
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end
        // One cycle of bundling margin before the requests rise
        SETUP: begin
          accumReq <= 1'b1;
          multReq  <= 1'b1;
          state    <= ISSUE;
        end
        ISSUE: begin
          if (s_a && s_m) begin
            accumReq <= 1'b0;
            multReq  <= 1'b0;
            state    <= COLLECT;
          end
        end
        // Input acks only fall after adderAck rises, so do not wait on them here
        COLLECT: begin
          if (s_r) begin
            sumOut   <= adderData;
            adderAck <= 1'b1;
            state    <= CLOSE;
          end
        end
        CLOSE: begin
          if (!s_r && !s_a && !s_m) begin
            adderAck         <= 1'b0;
            ackOut[grantId]  <= 1'b1;
            state            <= RESPOND;
          end
        end
        RESPOND: begin
          if (!reqIn[grantId]) begin
            ackOut <= '0;
            ptr    <= nxt_ptr;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
